uart_rx: RTL
============

Name: uart_rx

Overview:
- Receives UART frames on a serial input: 1 start bit, WORD_LENGTH data bits LSB first, 1 even-parity bit (parity bit = XOR of data bits), 1 stop bit.
- Presents each received word on a valid/ready output with per-word error flags.
- Receive-side counterpart of uart_tx; a uart_tx output looped into UART_RX is the primary integration case.

Parameters:
- CLKRATE, 100000000, clk frequency in Hz
- BAUD, 115200, line bit rate
- WORD_LENGTH, 8, data bits per frame

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- UART_RX  input  1  asynchronous serial line, idles high
- rx_data  output  WORD_LENGTH  received word, LSB = first data bit on the line
- rx_data_valid  output  1  rx_data and error flags valid; held until accepted
- rx_data_ready  input  1  consumer accepts the word when valid&ready
- rx_parity_err  output  1  word failed the even-parity check; qualified by rx_data_valid
- rx_frame_err  output  1  stop bit sampled low; qualified by rx_data_valid
- rx_overrun  output  1  one-cycle pulse: a completed word was dropped

Behaviour:
- UART_RX passes through a 2-flop synchronizer whose flops reset to 1.
  - All logic below uses the synchronized line, rx_s, which is 2 cycles late.
- BIT_MAX = CLKRATE/BAUD (integer division; 868 at the defaults); HALF_MAX = BIT_MAX/2.
  - The baud counter is sized $clog2(BIT_MAX) bits and clears on every state change.
- Reset values: rx_data=0, rx_data_valid=0, both error flags 0, rx_overrun=0, state IDLE, synchronizer flops 1.
- Reset mid-frame aborts the frame. Nothing is output for it.
- IDLE:
  - A falling edge on rx_s (previous sample 1, current sample 0) goes to START.
  - A line held low (break) causes no re-trigger; IDLE waits for a high sample first.
- START:
  - At count HALF_MAX-1, sample rx_s.
  - Sample = 1: false start, return to IDLE, no output.
  - Sample = 0: go to DATA. This anchors all later samples at mid-bit.
- DATA:
  - Every BIT_MAX cycles, shift rx_s into the MSB of the shift register (right shift).
  - After WORD_LENGTH samples, go to PARITY.
- PARITY: sample after BIT_MAX cycles; parity_bad = sample XOR (^shift register).
- STOP:
  - Sample after BIT_MAX cycles; frame_bad = ~sample.
  - Go to IDLE on that same cycle (mid stop bit), so a back-to-back start edge is caught.
- Output register, written on the cycle after the stop sample:
  - If rx_data_valid=0, or it is being accepted that cycle: load rx_data and both error flags, set rx_data_valid=1.
  - Otherwise: drop the new word, pulse rx_overrun for 1 cycle, leave the held word unchanged.
- Words with errors are still delivered, with the flags set.
- rx_data_valid falls the cycle after the valid&ready handshake. ready may be high permanently.
- Latency: rx_data_valid rises 2 sync cycles + 1 cycle after the mid-stop-bit sample.
- The uart_tx trailing idle bit (WAIT) needs no handling; it is seen as line idle.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each bit decision is a 2-of-3 majority of rx_s at counts target-1, target, target+1 around each sample point.
  - The false-start check uses the same vote.
  - Decisions are made at target+1, which adds 1 cycle of latency.
- Undefined: a single sample at the target count, as described above.

Decomposition:
- Package uart_pkg holds:
  - the state enum typedef {IDLE, START, DATA, PARITY, STOP, WAIT}; uart_rx uses a subset;
  - line constants TX_IDLE=1, TX_START=0, TX_STOP=1;
  - a function bit_max(clkrate, baud).
- Sub-module uart_rx_sync: 2-flop synchronizer plus falling-edge detect, reset to 1. Reusable by other async inputs.

Test Plan:
- Loopback from uart_tx, words 0xA5, 0x00, 0xFF sent back-to-back, ready=1 -> three valids, data matching in order, all flags 0.
- Frame 0x3C (even-parity bit 0) sent with the parity bit forced to 1 -> rx_data=0x3C, rx_parity_err=1, rx_frame_err=0.
- Frame 0x81 with the stop bit driven low, line then held low for 20 bit times -> one word, rx_frame_err=1, no second start until the line returns high.
- Low glitch of 200 cycles on an idle line (shorter than HALF_MAX=434) -> no rx_data_valid, FSM back in IDLE.
- ready=0 while two frames 0x11 and 0x22 arrive -> rx_data holds 0x11, rx_overrun pulses once at the end of 0x22; after ready=1, valid drops the next cycle.
- rst asserted for 1 cycle in the middle of the DATA bits, then a clean 0x5A frame -> the aborted frame is never output; 0x5A is received with no errors.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART state encoding, line levels and baud helper.
// Revision : 1.0
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    WAIT   = 3'd5
  } uart_state_t;

  localparam logic TX_IDLE  = 1'b1;
  localparam logic TX_START = 1'b0;
  localparam logic TX_STOP  = 1'b1;

  function automatic int bit_max(input int clkrate, input int baud);
    return clkrate / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sync
// Brief    : Two-flop synchronizer with falling-edge detect, resets to idle-high.
// Revision : 1.0
// ============================================================================
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic fall
);

  logic meta;
  logic sync_q;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= TX_IDLE;
      sync_q <= TX_IDLE;
      prev   <= TX_IDLE;
    end else begin
      meta   <= async_in;
      sync_q <= meta;
      prev   <= sync_q;
    end
  end

  assign sync_out = sync_q;
  // A line held low never re-fires: prev must have seen a high sample first.
  assign fall     = prev & ~sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : UART receiver, 8E1-style framing (even parity), valid/ready output.
//            Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions.
// Revision : 1.0
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKRATE     = 100000000,
  parameter int BAUD        = 115200,
  parameter int WORD_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   UART_RX,
  output logic [WORD_LENGTH-1:0] rx_data,
  output logic                   rx_data_valid,
  input  logic                   rx_data_ready,
  output logic                   rx_parity_err,
  output logic                   rx_frame_err,
  output logic                   rx_overrun
);

  localparam int BIT_MAX  = bit_max(CLKRATE, BAUD);
  localparam int HALF_MAX = BIT_MAX / 2;
  localparam int CW       = $clog2(BIT_MAX);
  localparam int BW       = $clog2(WORD_LENGTH + 1);

  logic rx_s;
  logic rx_fall;
  logic bit_val;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (UART_RX),
    .sync_out (rx_s),
    .fall     (rx_fall)
  );

`ifdef UART_RX_MAJORITY_EN
  // Vote window is target-1..target+1; deciding one count late keeps every
  // later decision on the same BIT_MAX period once START has absorbed the lag.
  localparam int DEC_LAG = 1;
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (rst) hist <= {2{TX_IDLE}};
    else     hist <= {hist[0], rx_s};
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  localparam int DEC_LAG = 0;
  assign bit_val = rx_s;
`endif

  localparam logic [CW-1:0] START_DEC = CW'(HALF_MAX - 1 + DEC_LAG);
  localparam logic [CW-1:0] BIT_DEC   = CW'(BIT_MAX - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(WORD_LENGTH - 1);

  uart_state_t            state, state_n;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          nbits;
  logic [WORD_LENGTH-1:0] shreg;
  logic                   parity_bad;
  logic                   frame_bad;
  logic                   done;
  logic                   at_start_dec;
  logic                   at_bit_dec;

  assign at_start_dec = (cnt == START_DEC);
  assign at_bit_dec   = (cnt == BIT_DEC);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (rx_fall) state_n = START;
      START:   if (at_start_dec) state_n = (bit_val == TX_START) ? DATA : IDLE;
      DATA:    if (at_bit_dec && (nbits == BITS_LAST)) state_n = PARITY;
      PARITY:  if (at_bit_dec) state_n = STOP;
      STOP:    if (at_bit_dec) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      nbits      <= '0;
      shreg      <= '0;
      parity_bad <= 1'b0;
      frame_bad  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state_n != state) || (state == IDLE) || at_bit_dec) cnt <= '0;
      else                                                     cnt <= cnt + CW'(1);

      case (state)
        START: nbits <= '0;
        DATA: begin
          if (at_bit_dec) begin
            shreg <= {bit_val, shreg[WORD_LENGTH-1:1]};
            nbits <= nbits + BW'(1);
          end
        end
        PARITY: if (at_bit_dec) parity_bad <= bit_val ^ (^shreg);
        STOP: begin
          if (at_bit_dec) begin
            frame_bad <= (bit_val != TX_STOP);
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A completed word only displaces the held one if that word leaves this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (done) begin
        if (!rx_data_valid || rx_data_ready) begin
          rx_data       <= shreg;
          rx_parity_err <= parity_bad;
          rx_frame_err  <= frame_bad;
          rx_data_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_data_valid && rx_data_ready) begin
        rx_data_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
